// File: rtl/tdm_demux4_pkg.sv
// Shared constants and FSM encoding for the 4-channel TDM demultiplexer.
package tdm_demux4_pkg;

   localparam int unsigned NUM_CH = 4;

   localparam logic [1:0] SLOT0 = 2'd0;
   localparam logic [1:0] SLOT1 = 2'd1;
   localparam logic [1:0] SLOT2 = 2'd2;
   localparam logic [1:0] SLOT3 = 2'd3;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Framing FSM for the TDM demux: tracks the expected slot, flags framing
// violations and produces a one-hot write enable for the channel datapath.
module tdm_slot_ctrl
   import tdm_demux4_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic                i_sync,
   output logic [NUM_CH-1:0]   o_wr_en,
   output logic                o_locked,
   output logic [1:0]          o_slot_ptr,
   output logic                o_sync_err
);

   state_t              r_state;
   state_t              w_state_d;
   logic [1:0]          r_ptr;
   logic [1:0]          w_ptr_d;
   logic                r_sync_err;
   logic                w_err;
   logic [NUM_CH-1:0]   w_wr_en;

   // State, slot pointer and registered error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= HUNT;
         r_ptr      <= SLOT0;
         r_sync_err <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_ptr      <= w_ptr_d;
         r_sync_err <= w_err;
      end
   end

   // Next-state, pointer advance, write steering and violation detection.
   always_comb begin
      w_state_d = r_state;
      w_ptr_d   = r_ptr;
      w_wr_en   = '0;
      w_err     = 1'b0;
      if (i_valid) begin
         unique case (r_state)
            HUNT: begin
               // Words without sync are silently dropped while hunting.
               if (i_sync) begin
                  w_wr_en   = 4'b0001;
                  w_ptr_d   = SLOT1;
                  w_state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (i_sync) begin
                  // Sync always restarts the frame at slot 0; early sync is an error.
                  w_wr_en = 4'b0001;
                  w_ptr_d = SLOT1;
                  w_err   = (r_ptr != SLOT0);
               end else if (r_ptr == SLOT0) begin
                  w_err     = 1'b1;
                  w_ptr_d   = SLOT0;
                  w_state_d = HUNT;
               end else begin
                  w_wr_en = 4'(4'b0001 << r_ptr);
                  w_ptr_d = r_ptr + 2'd1;
               end
            end
            default: begin
               w_state_d = HUNT;
               w_ptr_d   = SLOT0;
            end
         endcase
      end
   end

   assign o_wr_en    = w_wr_en;
   assign o_locked   = (r_state == LOCKED);
   assign o_slot_ptr = r_ptr;
   assign o_sync_err = r_sync_err;

endmodule

// File: rtl/tdm_demux4.sv
// 4-channel TDM demultiplexer: steers slot words into holding registers and
// publishes each complete frame atomically when slot 3 arrives.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 frame_sync,
   output logic [4*WIDTH-1:0]   frame_out,
   output logic                 frame_valid,
   output logic                 locked,
   output logic [1:0]           slot_ptr,
   output logic                 sync_err
);

   logic [NUM_CH-1:0]   w_wr_en;
   logic [WIDTH-1:0]    r_ch0;
   logic [WIDTH-1:0]    r_ch1;
   logic [WIDTH-1:0]    r_ch2;
   logic [4*WIDTH-1:0]  r_frame_out;
   logic                r_frame_valid;

   tdm_slot_ctrl u_slot_ctrl (
      .clk        (clk),
      .rst        (rst),
      .i_valid    (din_valid),
      .i_sync     (frame_sync),
      .o_wr_en    (w_wr_en),
      .o_locked   (locked),
      .o_slot_ptr (slot_ptr),
      .o_sync_err (sync_err)
   );

   // Holding registers for slots 0..2; slot 3 goes straight into the frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch0 <= '0;
         r_ch1 <= '0;
         r_ch2 <= '0;
      end else begin
         if (w_wr_en[0]) r_ch0 <= din;
         if (w_wr_en[1]) r_ch1 <= din;
         if (w_wr_en[2]) r_ch2 <= din;
      end
   end

   // Frame publish: only a slot-3 write updates frame_out and pulses valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_out   <= '0;
         r_frame_valid <= 1'b0;
      end else begin
         r_frame_valid <= w_wr_en[3];
         if (w_wr_en[3]) r_frame_out <= {din, r_ch2, r_ch1, r_ch0};
      end
   end

   assign frame_out   = r_frame_out;
   assign frame_valid = r_frame_valid;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
module tb_tdm_demux4;

   logic        clk;
   logic        rst;
   logic [7:0]  din;
   logic        din_valid;
   logic        frame_sync;
   logic [31:0] frame_out;
   logic        frame_valid;
   logic        locked;
   logic [1:0]  slot_ptr;
   logic        sync_err;

   int n_tests;
   int n_fail;

   tdm_demux4 #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .frame_out   (frame_out),
      .frame_valid (frame_valid),
      .locked      (locked),
      .slot_ptr    (slot_ptr),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one input cycle; returns 1ns after the sampling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic s);
      @(negedge clk);
      din        = d;
      din_valid  = v;
      frame_sync = s;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      rst        = 1'b1;
      din        = '0;
      din_valid  = 1'b0;
      frame_sync = 1'b0;
      #12;
      check("rst_frame_out", frame_out, 32'h0);
      check("rst_fv", {31'b0, frame_valid}, 32'h0);
      check("rst_locked", {31'b0, locked}, 32'h0);
      check("rst_ptr", {30'b0, slot_ptr}, 32'h0);
      check("rst_err", {31'b0, sync_err}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Basic frame
      step(1'b1, 8'hA1, 1'b1);
      check("t1_locked", {31'b0, locked}, 32'h1);
      check("t1_ptr1", {30'b0, slot_ptr}, 32'h1);
      step(1'b1, 8'hB2, 1'b0);
      check("t1_ptr2", {30'b0, slot_ptr}, 32'h2);
      step(1'b1, 8'hC3, 1'b0);
      check("t1_ptr3", {30'b0, slot_ptr}, 32'h3);
      check("t1_fv_early", {31'b0, frame_valid}, 32'h0);
      check("t1_fo_partial", frame_out, 32'h0);
      step(1'b1, 8'hD4, 1'b0);
      check("t1_fo", frame_out, 32'hD4C3B2A1);
      check("t1_fv", {31'b0, frame_valid}, 32'h1);
      check("t1_ptr0", {30'b0, slot_ptr}, 32'h0);
      check("t1_locked2", {31'b0, locked}, 32'h1);
      step(1'b0, 8'h00, 1'b0);
      check("t1_fv_width", {31'b0, frame_valid}, 32'h0);
      check("t1_fo_hold", frame_out, 32'hD4C3B2A1);

      // HUNT drop
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h55, 1'b0);
      check("t2_locked", {31'b0, locked}, 32'h0);
      check("t2_err", {31'b0, sync_err}, 32'h0);
      check("t2_ptr", {30'b0, slot_ptr}, 32'h0);
      step(1'b1, 8'h11, 1'b1);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      step(1'b1, 8'h44, 1'b0);
      check("t2_fo", frame_out, 32'h44332211);
      check("t2_fv", {31'b0, frame_valid}, 32'h1);

      // Early sync
      step(1'b1, 8'h01, 1'b1);
      step(1'b1, 8'h02, 1'b0);
      check("t3_err_pre", {31'b0, sync_err}, 32'h0);
      step(1'b1, 8'h10, 1'b1);
      check("t3_err", {31'b0, sync_err}, 32'h1);
      check("t3_ptr", {30'b0, slot_ptr}, 32'h1);
      check("t3_locked", {31'b0, locked}, 32'h1);
      check("t3_fo_hold", frame_out, 32'h44332211);
      step(1'b1, 8'h20, 1'b0);
      check("t3_err_width", {31'b0, sync_err}, 32'h0);
      step(1'b1, 8'h30, 1'b0);
      step(1'b1, 8'h40, 1'b0);
      check("t3_fo", frame_out, 32'h40302010);
      check("t3_fv", {31'b0, frame_valid}, 32'h1);
      check("t3_no_err", {31'b0, sync_err}, 32'h0);

      // Missing sync
      step(1'b1, 8'h77, 1'b0);
      check("t4_err", {31'b0, sync_err}, 32'h1);
      check("t4_locked", {31'b0, locked}, 32'h0);
      check("t4_fo", frame_out, 32'h40302010);
      check("t4_fv", {31'b0, frame_valid}, 32'h0);
      check("t4_ptr", {30'b0, slot_ptr}, 32'h0);

      // Gaps between slots
      step(1'b1, 8'hAA, 1'b1);
      check("t5_ptr1", {30'b0, slot_ptr}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'hEE, 1'b1);
         check("t5_gap_ptr1", {30'b0, slot_ptr}, 32'h1);
      end
      step(1'b1, 8'hBB, 1'b0);
      check("t5_ptr2", {30'b0, slot_ptr}, 32'h2);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'hEE, 1'b1);
         check("t5_gap_ptr2", {30'b0, slot_ptr}, 32'h2);
      end
      step(1'b1, 8'hCC, 1'b0);
      check("t5_ptr3", {30'b0, slot_ptr}, 32'h3);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'hEE, 1'b0);
         check("t5_gap_ptr3", {30'b0, slot_ptr}, 32'h3);
         check("t5_gap_fv", {31'b0, frame_valid}, 32'h0);
      end
      step(1'b1, 8'hDD, 1'b0);
      check("t5_fo", frame_out, 32'hDDCCBBAA);
      check("t5_fv", {31'b0, frame_valid}, 32'h1);
      check("t5_ptr0", {30'b0, slot_ptr}, 32'h0);
      step(1'b0, 8'h00, 1'b0);
      check("t5_fv_width", {31'b0, frame_valid}, 32'h0);

      // Async reset mid-frame
      step(1'b1, 8'h01, 1'b1);
      step(1'b1, 8'h02, 1'b0);
      step(1'b1, 8'h03, 1'b0);
      din_valid = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("t6_fo_clr", frame_out, 32'h0);
      check("t6_locked", {31'b0, locked}, 32'h0);
      check("t6_ptr", {30'b0, slot_ptr}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 8'h04, 1'b0);
      check("t6_fv", {31'b0, frame_valid}, 32'h0);
      check("t6_fo", frame_out, 32'h0);
      check("t6_locked2", {31'b0, locked}, 32'h0);
      check("t6_err", {31'b0, sync_err}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
